dpram_be_clr: RTL and testbench
===============================

# dpram_be_clr

Single-clock, true dual-port RAM, generalised from the team's basic dual-port RAM. Adds per-byte write enables, a selectable read-during-write mode, an optional output register stage and a hardware clear sequencer. The sequencer fills the array with a known value after reset or on request, because synthesised RAM cannot rely on simulation-only initialisation. It serves as shared storage between the input-capture logic and the CPU/video side, where deterministic power-up contents and partial-word updates are required.

## Interface
Parameters:
- address_width, 10, address bits; depth = 2**address_width
- data_width, 16, word width; must be a multiple of byte_width
- byte_width, 8, bits per byte-enable lane; lanes = data_width/byte_width
- rdw_mode, 0, same-port read-during-write: 0 = new data, 1 = old data
- output_reg, 0, 1 adds an output register stage to both q ports
- clear_value, 0, word written to every address by the clear sequencer

Ports:
- clock  in  1  single clock for both ports
- reset_n  in  1  asynchronous, active-low reset
- clear  in  1  single-cycle request to refill the array with clear_value
- busy  out  1  high while the clear sequence runs
- wren_a  in  1  port A write strobe
- be_a  in  lanes  port A byte enables
- address_a  in  address_width  port A address
- data_a  in  data_width  port A write data
- q_a  out  data_width  port A read data
- wren_b, be_b, address_b, data_b, q_b: same as port A, for port B

## Operation
- Reset values: q_a = 0, q_b = 0, all pipeline registers = 0, busy = 1, sequencer state = CLEAR, clear counter = 0. Array contents are not reset.
- Sequencer states:
  - CLEAR: writes clear_value to address = counter, increments counter each cycle. Leaves for IDLE after address depth-1 is written. Duration is exactly depth cycles.
  - IDLE: waits for requests. clear=1 moves to CLEAR with counter = 0. clear is ignored while in CLEAR.
- While busy: wren_a/wren_b are ignored, and q_a/q_b read 0.
- Writes: on a rising edge with wren_x=1, each lane i with be_x[i]=1 is written from data_x. Lanes with be_x[i]=0 keep their value. wren_x=1 with be_x=0 is a no-op write.
- Same-port read-during-write:
  - rdw_mode 0: q_x returns the merged word (new enabled lanes, old other lanes).
  - rdw_mode 1: q_x returns the pre-write word.
- Cross-port read of an address written by the other port in the same cycle always returns the old word.
- Both ports write the same address in the same cycle: port A wins on lanes enabled by both. Each port's other enabled lanes are written normally.
- An async reset during CLEAR restarts the sequence from address 0 after reset release.

## Timing
- Read latency: 1 cycle when output_reg=0, 2 cycles when output_reg=1; identical on both ports.
- Write takes effect at the edge where wren_x is sampled. A read of that address issued on the next cycle sees the new data.
- After reset release, busy stays 1 for exactly depth cycles. First user write is accepted on cycle depth+1.
- clear sampled in IDLE: busy rises on the next cycle and stays high for depth cycles.
- With output_reg=1, q outputs read 0 for one extra cycle after busy falls (pipeline flush).

## Structure
- Shared package dpram_pkg:
  - RDW_NEW_DATA = 0, RDW_OLD_DATA = 1
  - sequencer state encoding: IDLE, CLEAR
  - function computing lanes from data_width and byte_width
- Sub-module dpram_clear_seq: sequencer FSM, address counter and busy output. It drives an internal write port muxed ahead of port A; port B stays blocked while busy.
- The array is one memory with per-lane write logic. Inference as block RAM with byte enables is required.

## Test plan
- Reset release, depth=16 → busy=1 for 16 cycles. Reads at addresses 0..15 then return clear_value=0x0000.
- Port A writes 0xABCD with be_a=2'b01 at address 5, which holds 0x1234 → later read at address 5 returns 0x12CD.
- rdw_mode=0: same-port write 0x5555 to address 3, which holds 0x1111 → q_a=0x5555. rdw_mode=1 → q_a=0x1111. Port B reading address 3 in that cycle gets 0x1111 in both modes.
- Both ports write address 7 same cycle: A writes 0xAAAA with be=11, B writes 0xBBBB with be=10 → address 7 = 0xAAAA. With A be=01 and B be=10 → 0xBBAA.
- clear pulse in IDLE with writes on both ports during busy → writes are dropped. After 16 cycles every address reads clear_value.
- reset_n asserted at counter=9 mid-clear, then released → busy=1 for 16 full cycles, and q_a=q_b=0 during reset.

Source files
------------

// File: rtl/dpram_pkg.sv
// Shared constants, sequencer state type and lane helper for the byte-enabled
// dual-port RAM and its clear sequencer.
package dpram_pkg;

  localparam int RDW_NEW_DATA = 0;
  localparam int RDW_OLD_DATA = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } seq_state_e;

  function automatic int lanes_f(input int data_w, input int byte_w);
    return data_w / byte_w;
  endfunction

endpackage

// File: rtl/dpram_clear_seq.sv
// Clear sequencer: sweeps every address once after reset or on request and
// owns the port A write path while it runs.
//
//   state | meaning
//   CLEAR | writing clear_value at cnt_q, one address per cycle; user ports blocked
//   IDLE  | array released to the user ports; waits for clear_i
module dpram_clear_seq import dpram_pkg::*; #(
  parameter int address_width = 10
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clear_i,
  output logic                     busy_o,
  output logic                     wr_en_o,
  output logic [address_width-1:0] wr_addr_o
);

  seq_state_e               state_q, state_d;
  logic [address_width-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // clear_i is only looked at in IDLE, so a request during a sweep is dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + address_width'(1);
        if (cnt_q == {address_width{1'b1}}) state_d = IDLE;
      end
      IDLE: begin
        if (clear_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    busy_o    = (state_q == CLEAR);
    wr_en_o   = (state_q == CLEAR);
    wr_addr_o = cnt_q;
  end

endmodule

// File: rtl/dpram_be_clr.sv
// Single-clock true dual-port RAM with per-byte write enables, selectable
// same-port read-during-write, optional output register and hardware clear.
module dpram_be_clr import dpram_pkg::*; #(
  parameter int                    address_width = 10,
  parameter int                    data_width    = 16,
  parameter int                    byte_width    = 8,
  parameter int                    rdw_mode      = 0,
  parameter int                    output_reg    = 0,
  parameter logic [data_width-1:0] clear_value   = '0
) (
  input  logic                                            clock,
  input  logic                                            reset_n,
  input  logic                                            clear,
  output logic                                            busy,
  input  logic                                            wren_a,
  input  logic [lanes_f(data_width, byte_width)-1:0]      be_a,
  input  logic [address_width-1:0]                        address_a,
  input  logic [data_width-1:0]                           data_a,
  output logic [data_width-1:0]                           q_a,
  input  logic                                            wren_b,
  input  logic [lanes_f(data_width, byte_width)-1:0]      be_b,
  input  logic [address_width-1:0]                        address_b,
  input  logic [data_width-1:0]                           data_b,
  output logic [data_width-1:0]                           q_b
);

  localparam int LANES = lanes_f(data_width, byte_width);
  localparam int DEPTH = 2 ** address_width;

  logic                     seq_wr_en;
  logic [address_width-1:0] seq_wr_addr;

  dpram_clear_seq #(
    .address_width(address_width)
  ) u_clear_seq (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear_i  (clear),
    .busy_o   (busy),
    .wr_en_o  (seq_wr_en),
    .wr_addr_o(seq_wr_addr)
  );

  logic                     we_a, we_b;
  logic [LANES-1:0]         wa_be;
  logic [address_width-1:0] wa_addr;
  logic [data_width-1:0]    wa_data;

  // The sequencer takes over the port A write path; port B is simply gated.
  always_comb begin
    we_a = wren_a & ~busy;
    we_b = wren_b & ~busy;
    if (seq_wr_en) begin
      wa_be   = '1;
      wa_addr = seq_wr_addr;
      wa_data = clear_value;
    end else begin
      wa_be   = we_a ? be_a : '0;
      wa_addr = address_a;
      wa_data = data_a;
    end
  end

  logic [data_width-1:0] mem [DEPTH];

  // Port A is assigned last so it wins lanes both ports write at one address.
  always_ff @(posedge clock) begin
    for (int i = 0; i < LANES; i++) begin
      if (we_b && be_b[i])
        mem[address_b][i*byte_width +: byte_width] <= data_b[i*byte_width +: byte_width];
      if (wa_be[i])
        mem[wa_addr][i*byte_width +: byte_width] <= wa_data[i*byte_width +: byte_width];
    end
  end

  logic [data_width-1:0] old_a, old_b, merged_a, merged_b;
  logic [data_width-1:0] rd_a_d, rd_b_d, rd_a_q, rd_b_q;

  // Merged words only fold in the reading port's own lanes; the other port's
  // same-cycle write is never visible here.
  always_comb begin
    old_a    = mem[address_a];
    old_b    = mem[address_b];
    merged_a = old_a;
    merged_b = old_b;
    for (int i = 0; i < LANES; i++) begin
      if (we_a && be_a[i]) merged_a[i*byte_width +: byte_width] = data_a[i*byte_width +: byte_width];
      if (we_b && be_b[i]) merged_b[i*byte_width +: byte_width] = data_b[i*byte_width +: byte_width];
    end
    if (busy) begin
      rd_a_d = '0;
      rd_b_d = '0;
    end else if (rdw_mode == RDW_OLD_DATA) begin
      rd_a_d = old_a;
      rd_b_d = old_b;
    end else begin
      rd_a_d = merged_a;
      rd_b_d = merged_b;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else begin
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
    end
  end

  generate
    if (output_reg != 0) begin : g_out_reg
      logic [data_width-1:0] q_a_q, q_b_q;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          q_a_q <= '0;
          q_b_q <= '0;
        end else begin
          q_a_q <= rd_a_q;
          q_b_q <= rd_b_q;
        end
      end

      assign q_a = q_a_q;
      assign q_b = q_b_q;
    end else begin : g_no_out_reg
      assign q_a = rd_a_q;
      assign q_b = rd_b_q;
    end
  endgenerate

endmodule

// File: tb/tb_dpram_be_clr.sv
// Directed bench: two instances (new-data/unregistered and old-data/registered)
// share one stimulus stream and are checked against hand-computed words.
module tb_dpram_be_clr;

  localparam logic [15:0] CV0 = 16'h0000;
  localparam logic [15:0] CV1 = 16'h5A3C;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        clear = 1'b0;
  logic        wren_a = 1'b0, wren_b = 1'b0;
  logic [1:0]  be_a = 2'b00, be_b = 2'b00;
  logic [3:0]  address_a = 4'd0, address_b = 4'd0;
  logic [15:0] data_a = 16'h0, data_b = 16'h0;
  logic        busy0, busy1;
  logic [15:0] q_a0, q_b0, q_a1, q_b1;

  int          n_chk = 0;
  int          n_pass = 0;
  int          c0, c1;
  logic [15:0] exp0 [16];
  logic [15:0] exp1 [16];

  always #5 clock = ~clock;

  dpram_be_clr #(
    .address_width(4), .data_width(16), .byte_width(8),
    .rdw_mode(0), .output_reg(0), .clear_value(CV0)
  ) dut0 (
    .clock(clock), .reset_n(reset_n), .clear(clear), .busy(busy0),
    .wren_a(wren_a), .be_a(be_a), .address_a(address_a), .data_a(data_a), .q_a(q_a0),
    .wren_b(wren_b), .be_b(be_b), .address_b(address_b), .data_b(data_b), .q_b(q_b0)
  );

  dpram_be_clr #(
    .address_width(4), .data_width(16), .byte_width(8),
    .rdw_mode(1), .output_reg(1), .clear_value(CV1)
  ) dut1 (
    .clock(clock), .reset_n(reset_n), .clear(clear), .busy(busy1),
    .wren_a(wren_a), .be_a(be_a), .address_a(address_a), .data_a(data_a), .q_a(q_a1),
    .wren_b(wren_b), .be_b(be_b), .address_b(address_b), .data_b(data_b), .q_b(q_b1)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic wr(input logic wa, input logic [1:0] ba, input logic [3:0] aa, input logic [15:0] da,
                    input logic wb, input logic [1:0] bb, input logic [3:0] ab, input logic [15:0] db);
    wren_a = wa; be_a = ba; address_a = aa; data_a = da;
    wren_b = wb; be_b = bb; address_b = ab; data_b = db;
    tick();
    wren_a = 1'b0; wren_b = 1'b0;
  endtask

  task automatic read_pair(input logic [3:0] aa, input logic [3:0] ab,
                           input logic [15:0] ea0, input logic [15:0] eb0,
                           input logic [15:0] ea1, input logic [15:0] eb1, input string tag);
    wren_a = 1'b0; wren_b = 1'b0; address_a = aa; address_b = ab;
    tick();
    check({tag, "_qa0"}, q_a0, ea0);
    check({tag, "_qb0"}, q_b0, eb0);
    tick();
    check({tag, "_qa1"}, q_a1, ea1);
    check({tag, "_qb1"}, q_b1, eb1);
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 16; i++)
      read_pair(4'(i), 4'(15 - i), exp0[i], exp0[15 - i], exp1[i], exp1[15 - i],
                $sformatf("%s_%0d", tag, i));
  endtask

  initial begin
    #2 reset_n = 1'b0;
    tick(); tick();
    check("rst_busy0", 16'(busy0), 16'd1);
    check("rst_qa0", q_a0, 16'h0);
    check("rst_qb0", q_b0, 16'h0);
    check("rst_busy1", 16'(busy1), 16'd1);
    check("rst_qa1", q_a1, 16'h0);
    check("rst_qb1", q_b1, 16'h0);

    // Release; writes held through the whole busy window must be dropped,
    // the write presented right after busy falls must land.
    reset_n = 1'b1;
    wren_a = 1'b1; be_a = 2'b11; address_a = 4'd1; data_a = 16'hFFFF;
    wren_b = 1'b1; be_b = 2'b11; address_b = 4'd2; data_b = 16'hEEEE;
    c0 = 0; c1 = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy0) c0++;
      if (busy1) c1++;
      if (k == 16) begin
        address_a = 4'd10; data_a = 16'hC0DE;
        address_b = 4'd11; data_b = 16'hBEEF;
      end
      if (k == 17) begin wren_a = 1'b0; wren_b = 1'b0; end
      tick();
    end
    check("init_busy_cycles0", 16'(c0), 16'd16);
    check("init_busy_cycles1", 16'(c1), 16'd16);

    for (int i = 0; i < 16; i++) begin exp0[i] = CV0; exp1[i] = CV1; end
    exp0[10] = 16'hC0DE; exp1[10] = 16'hC0DE;
    exp0[11] = 16'hBEEF; exp1[11] = 16'hBEEF;
    sweep("init");

    wr(1'b1, 2'b11, 4'd5, 16'h1234, 1'b0, 2'b00, 4'd0, 16'h0);
    wr(1'b1, 2'b01, 4'd5, 16'hABCD, 1'b0, 2'b00, 4'd0, 16'h0);
    read_pair(4'd5, 4'd5, 16'h12CD, 16'h12CD, 16'h12CD, 16'h12CD, "be_lane");

    // Same-port read-during-write, full word, with a cross-port observer.
    wr(1'b1, 2'b11, 4'd3, 16'h1111, 1'b0, 2'b00, 4'd0, 16'h0);
    wren_a = 1'b1; be_a = 2'b11; address_a = 4'd3; data_a = 16'h5555;
    wren_b = 1'b0; address_b = 4'd3;
    tick();
    wren_a = 1'b0;
    check("rdw_new_qa0", q_a0, 16'h5555);
    check("rdw_cross_qb0", q_b0, 16'h1111);
    tick();
    check("rdw_old_qa1", q_a1, 16'h1111);
    check("rdw_cross_qb1", q_b1, 16'h1111);

    // Same-port read-during-write on a partial word.
    wr(1'b1, 2'b11, 4'd4, 16'h1234, 1'b0, 2'b00, 4'd0, 16'h0);
    wren_a = 1'b1; be_a = 2'b10; address_a = 4'd4; data_a = 16'hABCD;
    wren_b = 1'b0; address_b = 4'd4;
    tick();
    wren_a = 1'b0;
    check("rdw_merge_qa0", q_a0, 16'hAB34);
    check("rdw_merge_qb0", q_b0, 16'h1234);
    tick();
    check("rdw_merge_qa1", q_a1, 16'h1234);
    check("rdw_merge_qb1", q_b1, 16'h1234);
    read_pair(4'd4, 4'd3, 16'hAB34, 16'h5555, 16'hAB34, 16'h5555, "rdw_after");

    // Dual writes: collision priority, disjoint lanes, and distinct addresses.
    wr(1'b1, 2'b11, 4'd7, 16'hAAAA, 1'b1, 2'b10, 4'd7, 16'hBBBB);
    read_pair(4'd7, 4'd7, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, "coll_full");
    wr(1'b1, 2'b01, 4'd7, 16'hAAAA, 1'b1, 2'b10, 4'd7, 16'hBBBB);
    read_pair(4'd7, 4'd7, 16'hBBAA, 16'hBBAA, 16'hBBAA, 16'hBBAA, "coll_split");
    wr(1'b1, 2'b11, 4'd8, 16'h1357, 1'b1, 2'b11, 4'd9, 16'h2468);
    read_pair(4'd8, 4'd9, 16'h1357, 16'h2468, 16'h1357, 16'h2468, "dual_addr");

    // Clear request with writes during busy and a second request mid-sweep.
    address_a = 4'd12; address_b = 4'd13;
    check("pre_clear_busy0", 16'(busy0), 16'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    c0 = 0; c1 = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy0) c0++;
      if (busy1) c1++;
      if (k == 5) begin
        check("busy_qa1", q_a1, 16'h0);
        check("busy_qb1", q_b1, 16'h0);
      end
      if (k == 17) check("flush_qa1", q_a1, 16'h0);
      if (k == 18) begin
        check("post_clear_qa1", q_a1, CV1);
        check("post_clear_qb1", q_b1, CV1);
      end
      wren_a = (k < 16); be_a = 2'b11; data_a = 16'hDEAD;
      wren_b = (k < 16); be_b = 2'b11; data_b = 16'hFACE;
      clear = (k == 8);
      tick();
    end
    check("clr_busy_cycles0", 16'(c0), 16'd16);
    check("clr_busy_cycles1", 16'(c1), 16'd16);
    for (int i = 0; i < 16; i++) begin exp0[i] = CV0; exp1[i] = CV1; end
    sweep("clr");

    // Reset in the middle of a sweep restarts it from address 0.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (9) tick();
    reset_n = 1'b0;
    #1;
    check("midrst_busy0", 16'(busy0), 16'd1);
    check("midrst_busy1", 16'(busy1), 16'd1);
    check("midrst_qa0", q_a0, 16'h0);
    check("midrst_qb0", q_b0, 16'h0);
    check("midrst_qa1", q_a1, 16'h0);
    check("midrst_qb1", q_b1, 16'h0);
    tick(); tick();
    reset_n = 1'b1;
    c0 = 0; c1 = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy0) c0++;
      if (busy1) c1++;
      tick();
    end
    check("midrst_busy_cycles0", 16'(c0), 16'd16);
    check("midrst_busy_cycles1", 16'(c1), 16'd16);
    read_pair(4'd0, 4'd15, CV0, CV0, CV1, CV1, "midrst_read");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
